// File: rtl/apb_timer_slave.sv
`timescale 1ns/1ps
// APB completer with a 32-bit down-counting timer (CTRL, LOAD, COUNT, STATUS) and level interrupt.
// Defining APB_TIMER_WAIT_EN inserts WAIT_CYCLES wait states into every transfer.
module apb_timer_slave #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

`ifdef APB_TIMER_WAIT_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif
  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic addr_err(input logic [31:0] addr, input logic wr);
    return (addr[1:0] != 2'd0) || (addr[31:4] != 28'd0) || (wr && (addr[3:2] == 2'd2));
  endfunction

  function automatic logic [31:0] reg_read(
    input logic [1:0]  sel,
    input logic        en,
    input logic        auto_rl,
    input logic        ie,
    input logic [31:0] load,
    input logic [31:0] count,
    input logic        expd
  );
    logic [31:0] val;
    case (sel)
      2'd0:    val = {29'd0, ie, auto_rl, en};
      2'd1:    val = load;
      2'd2:    val = count;
      2'd3:    val = {31'd0, expd};
      default: val = 32'd0;
    endcase
    return val;
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  wait_cnt_r, wait_cnt_s;
  logic        pready_r, pready_s;
  logic        pslverr_r, pslverr_s;
  logic [31:0] prdata_r, prdata_s;

  logic        ctrl_en_r, ctrl_en_s;
  logic        ctrl_auto_r, ctrl_auto_s;
  logic        ctrl_ie_r, ctrl_ie_s;
  logic [31:0] load_r, load_s;
  logic [31:0] count_r, count_s;
  logic        exp_r, exp_s;

  logic        en_hw_s;
  logic [31:0] count_hw_s;
  logic        expire_s;
  logic        err_s;
  logic        commit_s;
  logic        bus_wr_s;

  assign err_s    = addr_err(PADDR, PWRITE);
  assign commit_s = PSEL & PENABLE & pready_r;
  assign bus_wr_s = commit_s & PWRITE & ~err_s;
  assign expire_s = ctrl_en_r & (count_r == 32'd0);

  // state_r holds the bus phase sampled on the last edge; response outputs are prepared one cycle ahead.
  always_comb begin
    state_s    = S_IDLE;
    wait_cnt_s = wait_cnt_r;
    pready_s   = 1'b0;
    case (state_r)
      S_IDLE, S_RESP: begin
        if (PSEL && !PENABLE) begin
          state_s    = S_SETUP;
          wait_cnt_s = 3'd0;
          pready_s   = ~WAIT_EN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        if (!PSEL) begin
          state_s = S_IDLE;
        end else if (pready_r) begin
          state_s = S_RESP;
        end else begin
          state_s    = S_WAIT;
          wait_cnt_s = 3'd1;
          pready_s   = (WAIT_N == 3'd1);
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_s = S_IDLE;
        end else if (pready_r) begin
          state_s = S_RESP;
        end else begin
          state_s    = S_WAIT;
          wait_cnt_s = wait_cnt_r + 3'd1;
          pready_s   = ((wait_cnt_r + 3'd1) == WAIT_N);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    pslverr_s = pready_s & err_s;
    prdata_s  = (pready_s && !PWRITE && !err_s)
              ? reg_read(PADDR[3:2], ctrl_en_s, ctrl_auto_s, ctrl_ie_s, load_s, count_s, exp_s)
              : 32'd0;
  end

  // Free-running timer behaviour before any bus write is applied.
  always_comb begin
    en_hw_s    = ctrl_en_r;
    count_hw_s = count_r;
    if (expire_s) begin
      if (ctrl_auto_r) begin
        count_hw_s = load_r;
      end else begin
        en_hw_s = 1'b0;
      end
    end else if (ctrl_en_r) begin
      count_hw_s = count_r - 32'd1;
    end else begin
      count_hw_s = count_r;
    end
  end

  // Bus writes override the timer's own CTRL/COUNT updates; a hardware EXP set beats a W1C.
  always_comb begin
    ctrl_en_s   = en_hw_s;
    ctrl_auto_s = ctrl_auto_r;
    ctrl_ie_s   = ctrl_ie_r;
    load_s      = load_r;
    count_s     = count_hw_s;
    exp_s       = exp_r | expire_s;
    if (bus_wr_s) begin
      case (PADDR[3:2])
        2'd0: begin
          ctrl_en_s   = PWDATA[0];
          ctrl_auto_s = PWDATA[1];
          ctrl_ie_s   = PWDATA[2];
          count_s     = (!ctrl_en_r && PWDATA[0]) ? load_r : count_hw_s;
        end
        2'd1: begin
          load_s  = PWDATA;
          count_s = (!ctrl_en_r || (expire_s && ctrl_auto_r)) ? PWDATA : count_hw_s;
        end
        2'd3: begin
          exp_s = expire_s | (exp_r & ~PWDATA[0]);
        end
        default: begin
          count_s = count_hw_s;
        end
      endcase
    end else begin
      ctrl_en_s = en_hw_s;
    end
  end

  // APB handshake state and pre-registered response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 3'd0;
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      prdata_r   <= 32'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      pready_r   <= pready_s;
      pslverr_r  <= pslverr_s;
      prdata_r   <= prdata_s;
    end
  end

  // Timer register file.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_en_r   <= 1'b0;
      ctrl_auto_r <= 1'b0;
      ctrl_ie_r   <= 1'b0;
      load_r      <= 32'd0;
      count_r     <= 32'd0;
      exp_r       <= 1'b0;
    end else begin
      ctrl_en_r   <= ctrl_en_s;
      ctrl_auto_r <= ctrl_auto_s;
      ctrl_ie_r   <= ctrl_ie_s;
      load_r      <= load_s;
      count_r     <= count_s;
      exp_r       <= exp_s;
    end
  end

  // Response is qualified by the live access phase so an abandoned transfer never shows PREADY.
  assign PREADY  = pready_r & PSEL & PENABLE;
  assign PSLVERR = pslverr_r & PSEL & PENABLE;
  assign PRDATA  = (PSEL && PENABLE) ? prdata_r : 32'd0;
  assign irq     = exp_r & ctrl_ie_r;

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, the number of ACCESS-phase wait cycles inserted when APB_TIMER_WAIT_EN is defined (legal range 1..7).
REQ-002 SHALL have port PCLK, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PSEL, input, 1, completer select from the APB master.
REQ-005 SHALL have port PENABLE, input, 1, ACCESS-phase indicator.
REQ-006 SHALL have port PWRITE, input, 1, 1=write, 0=read.
REQ-007 SHALL have port PADDR, input, 32, byte address.
REQ-008 SHALL have port PWDATA, input, 32, write data.
REQ-009 SHALL have port PRDATA, output, 32, read data.
REQ-010 SHALL have port PREADY, output, 1, transfer-complete indicator.
REQ-011 SHALL have port PSLVERR, output, 1, transfer error, valid only while PREADY=1.
REQ-012 SHALL have port irq, output, 1, timer interrupt, level, active-high.

Function
REQ-013 SHALL decode registers: 0x00 CTRL (RW; bit0 EN, bit1 AUTO, bit2 IE), 0x04 LOAD (RW, 32 b), 0x08 COUNT (RO, 32 b), 0x0C STATUS (bit0 EXP, write-1-to-clear).
REQ-014 SHALL flag an error for PADDR[1:0]!=0, PADDR[31:4]!=0, or a write to COUNT.
REQ-015 SHALL implement states IDLE, SETUP (PSEL=1, PENABLE=0), WAIT, RESP; IDLE->SETUP on PSEL; SETUP->RESP (no wait) or SETUP->WAIT (wait enabled); WAIT->RESP after WAIT_CYCLES cycles; RESP->SETUP if PSEL=1 and PENABLE=0 next, else IDLE.
REQ-016 SHALL drive PREADY=1 only in the completing ACCESS cycle, and 0 otherwise.
REQ-017 SHALL commit a write, or capture read data, only on the PCLK edge ending the cycle with PSEL=PENABLE=PREADY=1.
REQ-018 SHALL drive PRDATA with the addressed register value during the completing read cycle, and 0 at all other times, including on error transfers.
REQ-019 SHALL leave all registers unchanged on an error transfer and assert PSLVERR=1 with PREADY=1.
REQ-020 SHALL return to IDLE without committing if PSEL drops before completion.
REQ-021 SHALL load COUNT<=LOAD when CTRL.EN is written from 0 to 1, or when LOAD is written while EN=0.
REQ-022 SHALL, while EN=1 and COUNT!=0, decrement COUNT by 1 each PCLK.
REQ-023 SHALL, while EN=1 and COUNT==0, set STATUS.EXP; with AUTO=1 reload COUNT<=LOAD; with AUTO=0 clear EN and hold COUNT at 0.
REQ-024 SHALL, with LOAD=0 and AUTO=1, set EXP every cycle, with no wrap to 0xFFFFFFFF.
REQ-025 SHALL give the hardware set of EXP priority over a simultaneous W1C clear.
REQ-026 SHALL give a CTRL/LOAD bus write priority over a simultaneous hardware reload or EN clear in the same cycle.
REQ-027 SHALL drive irq = STATUS.EXP & CTRL.IE, combinationally from registers.

Reset
REQ-028 SHALL, on PRESETn=0, immediately force state IDLE, CTRL=0, LOAD=0, COUNT=0, STATUS=0, PREADY=0, PSLVERR=0, PRDATA=0, irq=0.
REQ-029 SHALL abort a transfer when reset asserts mid-transfer, with no write committed; after release, first accept a transfer only at a new SETUP phase.

Configuration
REQ-030 SHALL, when APB_TIMER_WAIT_EN is defined, insert WAIT_CYCLES cycles with PREADY=0 on every transfer, reads, writes and errors alike.
REQ-031 SHALL, when APB_TIMER_WAIT_EN is undefined, complete every transfer in the first ACCESS cycle (zero wait) and ignore WAIT_CYCLES.

Verification
REQ-032 SHALL cover: write LOAD=5, write CTRL=0x1 -> COUNT reads 5,4,..,0 on successive cycles; EXP=1; EN self-clears to 0.
REQ-033 SHALL cover: LOAD=3, CTRL=0x7 -> irq rises when COUNT hits 0, COUNT reloads 3; write STATUS=0x1 -> irq falls, then re-asserts 4 cycles later.
REQ-034 SHALL cover: read 0x10, read 0x02, write 0x08=0xFF -> PSLVERR=1, PRDATA=0, COUNT unchanged.
REQ-035 SHALL cover: APB_TIMER_WAIT_EN, WAIT_CYCLES=2 -> PREADY low for 2 ACCESS cycles then high for 1; without the macro, PREADY high in the first ACCESS cycle.
REQ-036 SHALL cover: PRESETn pulsed low during the WAIT of a CTRL write -> CTRL=0 and irq=0 after release; the next read of CTRL returns 0.
REQ-037 SHALL cover: W1C of STATUS on the same cycle as expiry -> EXP remains 1.
